conv_acc_master: RTL and testbench

Bus initiator for the convolution accelerator's word-addressed register port (en/we/addr/din/dout, single-cycle combinational read). It accepts a job command and a stream of kernel and window words, then writes them into the accelerator. It pulses start, polls status until done, reads the result and returns it on a valid/ready result channel. It sits between a CPU-side job queue or DMA and the accelerator, so software no longer needs to run the register protocol itself.

---
 rtl/conv_acc_pkg.sv | 14 +
 rtl/conv_acc_master.sv | 119 +++++++++++
 tb/tb_conv_acc_master.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/conv_acc_pkg.sv
// conv_acc_pkg: register map, status bits, tap count and master FSM states shared with the accelerator
package conv_acc_pkg;
  localparam int ADDR_CTRL   = 'h00;
  localparam int ADDR_STATUS = 'h01;
  localparam int ADDR_RESULT = 'h02;
  localparam int KERNEL_BASE = 'h10;
  localparam int WINDOW_BASE = 'h20;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int TAPS        = 9;
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_K, S_LOAD_W, S_START, S_SETTLE, S_POLL, S_READ, S_RESP
  } state_t;
endpackage

// File: rtl/conv_acc_master.sv
// conv_acc_master: loads kernel/window words into the convolution accelerator, starts it, polls and returns the result
// Optional cycle counter on res_cycles enabled by CONV_MASTER_PERF_EN.
module conv_acc_master
  import conv_acc_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 6,
  parameter int POLL_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load_kernel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_timeout,
  output logic [15:0]       res_cycles,
  output logic              busy,
  output logic              acc_en,
  output logic              acc_we,
  output logic [ADDR_W-1:0] acc_addr,
  output logic [DATA_W-1:0] acc_din,
  input  logic [DATA_W-1:0] acc_dout
);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  state_t state, nxt;
  logic [3:0] idx;
  logic [PW-1:0] polls;
  logic loading, last, done, poll_last;
  assign loading   = state == S_LOAD_K || state == S_LOAD_W;
  assign last      = idx == 4'(TAPS - 1);
  assign done      = acc_dout[STAT_DONE];
  assign poll_last = polls == PW'(POLL_LIMIT - 1);
  // cmd_ready is masked while reset is held so it reads 0 during reset
  assign cmd_ready = rst_n && state == S_IDLE;
  assign in_ready  = loading;
  assign busy      = state != S_IDLE;
  assign res_valid = state == S_RESP;
  always_comb begin
    nxt      = state;
    acc_en   = 1'b0;
    acc_we   = 1'b0;
    acc_addr = '0;
    acc_din  = '0;
    case (state)
      S_IDLE: if (cmd_valid) nxt = cmd_load_kernel ? S_LOAD_K : S_LOAD_W;
      S_LOAD_K, S_LOAD_W: if (in_valid) begin
        acc_en   = 1'b1;
        acc_we   = 1'b1;
        acc_addr = ADDR_W'(state == S_LOAD_K ? KERNEL_BASE : WINDOW_BASE) + ADDR_W'(idx);
        acc_din  = in_data;
        if (last) nxt = state == S_LOAD_K ? S_LOAD_W : S_START;
      end
      S_START: begin
        acc_en   = 1'b1;
        acc_we   = 1'b1;
        acc_addr = ADDR_W'(ADDR_CTRL);
        acc_din  = DATA_W'(1);
        nxt      = S_SETTLE;
      end
      // the previous job's done bit is still visible here, so the bus stays idle
      S_SETTLE: nxt = S_POLL;
      S_POLL: begin
        acc_en   = 1'b1;
        acc_addr = ADDR_W'(ADDR_STATUS);
        nxt      = done ? S_READ : poll_last ? S_RESP : S_POLL;
      end
      S_READ: begin
        acc_en   = 1'b1;
        acc_addr = ADDR_W'(ADDR_RESULT);
        nxt      = S_RESP;
      end
      S_RESP: if (res_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      polls       <= '0;
      res_data    <= '0;
      res_timeout <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE) idx <= '0;
      else if (loading && in_valid) idx <= last ? 4'd0 : idx + 4'd1;
      if (state == S_SETTLE) polls <= '0;
      else if (state == S_POLL && !done) polls <= polls + 1'b1;
      if (state == S_READ) begin
        res_data    <= acc_dout;
        res_timeout <= 1'b0;
      end else if (state == S_POLL && !done && poll_last) begin
        res_data    <= '0;
        res_timeout <= 1'b1;
      end
    end
  end
`ifdef CONV_MASTER_PERF_EN
  logic [15:0] cyc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc        <= '0;
      res_cycles <= '0;
    end else begin
      if (state == S_IDLE && cmd_valid) cyc <= '0;
      else if (state != S_IDLE && state != S_RESP && cyc != 16'hFFFF) cyc <= cyc + 16'd1;
      if (nxt == S_RESP && state != S_RESP) res_cycles <= cyc;
    end
  end
`else
  assign res_cycles = '0;
`endif
endmodule

// File: tb/tb_conv_acc_master.sv
// tb_conv_acc_master: randomized jobs against a behavioural accelerator and a dot-product reference model
module tb_conv_acc_master;
  localparam int PL = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_load_kernel = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [31:0] in_data = '0;
  logic res_valid, res_ready = 1'b0, res_timeout, busy;
  logic [31:0] res_data;
  logic [15:0] res_cycles;
  logic acc_en, acc_we;
  logic [5:0] acc_addr;
  logic [31:0] acc_din, acc_dout;
  int checks = 0, failures = 0;

  conv_acc_master #(.DATA_W(32), .ADDR_W(6), .POLL_LIMIT(PL)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load_kernel(cmd_load_kernel), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_timeout(res_timeout), .res_cycles(res_cycles), .busy(busy), .acc_en(acc_en),
    .acc_we(acc_we), .acc_addr(acc_addr), .acc_din(acc_din), .acc_dout(acc_dout));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dot(input logic [31:0] a[9], input logic [31:0] b[9]);
    logic [31:0] s = '0;
    for (int i = 0; i < 9; i++) s += a[i] * b[i];
    return s;
  endfunction

  // accelerator model: done from the previous job lingers one edge after start
  logic [31:0] kreg[9], wreg[9], ares = '0;
  logic adone = 1'b1, apend = 1'b0, astuck = 1'b0;
  int acnt = 0, alat = 2;
  initial for (int i = 0; i < 9; i++) begin kreg[i] = '0; wreg[i] = '0; end
  always_comb
    acc_dout = acc_addr == 6'h01 ? {30'b0, adone, acnt != 0} : acc_addr == 6'h02 ? ares : 32'h0;
  always @(posedge clk) begin
    if (acc_en && acc_we) begin
      if (acc_addr >= 6'h10 && acc_addr <= 6'h18) kreg[int'(acc_addr) - 16] <= acc_din;
      if (acc_addr >= 6'h20 && acc_addr <= 6'h28) wreg[int'(acc_addr) - 32] <= acc_din;
      if (acc_addr == 6'h00 && acc_din[0]) begin
        apend <= 1'b1;
        acnt  <= alat;
        ares  <= dot(kreg, wreg);
      end
    end
    if (apend) begin
      adone <= 1'b0;
      apend <= 1'b0;
    end
    if (acnt > 0) begin
      acnt <= acnt - 1;
      if (acnt == 1 && !astuck) adone <= 1'b1;
    end
  end

  // bus monitor
  logic [37:0] wr_q[$];
  int n_stat = 0, settle_bad = 0;
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (acc_en && acc_we) wr_q.push_back({acc_addr, acc_din});
    if (acc_en && !acc_we && acc_addr == 6'h01) n_stat++;
    if (prev_start && acc_en) settle_bad++;
    prev_start = acc_en && acc_we && acc_addr == 6'h00;
  end

  logic [31:0] kern[9], win[9], mk[9];

  task automatic run_job(input string nm, input bit lk, input int mode, input int hold, input bit stuck, input int lat);
    logic [31:0] w[18];
    logic [31:0] d, exp;
    logic [37:0] ew;
    int n, i, t, to;
    n = lk ? 18 : 9;
    for (int k = 0; k < 9; k++) begin
      w[k] = lk ? kern[k] : win[k];
      if (lk) w[k + 9] = win[k];
    end
    if (lk) mk = kern;
    exp = stuck ? 32'h0 : dot(mk, win);
    astuck = stuck;
    alat = lat;
    wr_q.delete();
    n_stat = 0;
    settle_bad = 0;
    @(posedge clk) #1;
    cmd_valid = 1'b1;
    cmd_load_kernel = lk;
    @(negedge clk);
    check({nm, ".cmd_ready"}, cmd_ready, 1);
    i = 0;
    t = 0;
    while (i < n && t < 400) begin
      @(posedge clk) #1;
      cmd_valid = 1'b0;
      in_valid = mode == 0 ? 1'b1 : mode == 1 ? t[0] == 1'b0 : 1'($urandom_range(0, 1));
      in_data = w[i];
      @(negedge clk);
      if (in_valid && in_ready) i++;
      t++;
    end
    @(posedge clk) #1;
    in_valid = 1'b0;
    in_data = $urandom;
    to = 0;
    while (!res_valid && to < 4 * PL + 40) begin
      @(negedge clk);
      to++;
    end
    check({nm, ".res_valid"}, res_valid, 1);
    d = res_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({nm, ".hold"}, {res_valid, cmd_ready, busy, res_data}, {3'b101, d});
    end
    check({nm, ".res_data"}, res_data, exp);
    check({nm, ".res_timeout"}, res_timeout, stuck);
`ifdef CONV_MASTER_PERF_EN
    check({nm, ".res_cycles"}, res_cycles, stuck ? t + 17 : t + lat + 2);
`else
    check({nm, ".res_cycles"}, res_cycles, 0);
`endif
    check({nm, ".polls"}, n_stat, stuck ? PL : lat);
    @(posedge clk) #1;
    res_ready = 1'b1;
    @(posedge clk) #1;
    res_ready = 1'b0;
    check({nm, ".idle"}, {cmd_ready, busy, res_valid}, 3'b100);
    check({nm, ".settle"}, settle_bad, 0);
    check({nm, ".wr_cnt"}, wr_q.size(), n + 1);
    for (int k = 0; k < n + 1 && k < wr_q.size(); k++) begin
      ew = k == n ? {6'h00, 32'h1} : (lk && k < 9) ? {6'h10 + 6'(k), kern[k]}
         : {6'h20 + 6'(k - (lk ? 9 : 0)), win[k - (lk ? 9 : 0)]};
      check({nm, ".wr"}, wr_q[k], ew);
    end
  endtask

  initial begin
    for (int k = 0; k < 9; k++) mk[k] = '0;
    #12;
    check("rst.ctl", {cmd_ready, in_ready, res_valid, res_timeout, busy, acc_en, acc_we}, 0);
    check("rst.data", {res_data, res_cycles, acc_addr, acc_din}, 0);
    @(posedge clk) #1 rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin kern[k] = 1; win[k] = k + 1; end
    run_job("basic", 1, 0, 0, 0, 2);
    for (int k = 0; k < 9; k++) begin kern[k] = k == 4 ? 2 : 0; win[k] = $urandom; end
    run_job("kload", 1, 0, 0, 0, 3);
    for (int k = 0; k < 9; k++) win[k] = k == 4 ? 32'hFFFFFFF9 : $urandom;
    run_job("reuse", 0, 0, 0, 0, 2);
    check("reuse.neg14", res_data, 32'hFFFFFFF2);
    for (int k = 0; k < 9; k++) begin kern[k] = $urandom; win[k] = $urandom; end
    run_job("toggle", 1, 1, 0, 0, 4);
    run_job("hold", 0, 0, 5, 0, 2);
    run_job("timeout", 0, 2, 0, 1, 2);
    // abort inside the window load after four words
    @(posedge clk) #1;
    cmd_valid = 1'b1;
    cmd_load_kernel = 1'b0;
    @(posedge clk) #1;
    cmd_valid = 1'b0;
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    check("abort.ctl", {cmd_ready, in_ready, res_valid, res_timeout, busy, acc_en, acc_we}, 0);
    check("abort.data", {res_data, res_cycles, acc_addr, acc_din}, 0);
    @(posedge clk) #1 rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin kern[k] = $urandom; win[k] = $urandom; end
    run_job("after_rst", 1, 0, 0, 0, 2);
    for (int j = 0; j < 5; j++) begin
      for (int k = 0; k < 9; k++) begin kern[k] = $urandom; win[k] = $urandom; end
      run_job("rand", 1'($urandom_range(0, 1)), 2, $urandom_range(0, 3), 0, $urandom_range(2, 6));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
